// File: rtl/pix_sse_cmp.sv
`default_nettype none
// ============================================================================
// Module      : pix_sse_cmp
// Description : Streaming image comparator. Accumulates the per-channel sum of
//               squared differences between pixel pairs of images A and B over
//               a frame of pix_num pixels. Optional per-channel max |a-b|
//               output is enabled by defining PIX_SSE_CMP_MAXDIFF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_sse_cmp #(
    parameter int DW    = 8,
    parameter int CH    = 3,
    parameter int CNT_W = 24,
    localparam int ACC_W = 2*DW + CNT_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [CNT_W-1:0]      pix_num,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [CH*DW-1:0]      a_pix,
    input  logic [CH*DW-1:0]      b_pix,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err,
    output logic [CH*ACC_W-1:0]   sse
`ifdef PIX_SSE_CMP_MAXDIFF_EN
    ,
    output logic [CH*DW-1:0]      max_diff
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } t_state;

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    t_state           r_state;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_len_err;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_pix_last;
    logic [2:0]       r_vld;

    logic             w_xfer;
    logic             w_clear;
    logic             w_at_end;
    logic             w_final;

    assign w_xfer   = in_valid && r_in_ready;
    assign w_clear  = (r_state == S_IDLE) && start;
    assign w_at_end = (r_count == r_pix_last);
    assign w_final  = w_at_end || in_last;

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign len_err  = r_len_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_len_err  <= 1'b0;
            r_count    <= '0;
            r_pix_last <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len_err <= 1'b0;
                        r_count   <= '0;
                        if (pix_num == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_pix_last <= pix_num - c_ONE;
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_count <= r_count + c_ONE;
                        if (w_final) begin
                            // Clean end only when the last flag lands exactly on beat pix_num
                            r_len_err  <= !(w_at_end && in_last);
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_vld == 3'b000) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage valids: [0] difference, [1] square, [2] accumulated.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld <= 3'b000;
        end else begin
            r_vld <= {r_vld[1:0], w_xfer};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [DW:0]      r_diff;
            logic [2*DW-1:0]  r_sq;
            logic [ACC_W-1:0] r_acc;
            logic [DW:0]      w_diff;
            logic [DW:0]      w_neg;
            logic [DW-1:0]    w_abs;
            logic [2*DW-1:0]  w_sq;

            assign w_diff = {1'b0, a_pix[gi*DW +: DW]} - {1'b0, b_pix[gi*DW +: DW]};
            assign w_neg  = (~r_diff) + {{DW{1'b0}}, 1'b1};
            // |diff| always fits in DW bits, so the square fits in 2*DW
            assign w_abs  = r_diff[DW] ? w_neg[DW-1:0] : r_diff[DW-1:0];
            assign w_sq   = {{DW{1'b0}}, w_abs} * {{DW{1'b0}}, w_abs};

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_diff <= '0;
                    r_sq   <= '0;
                    r_acc  <= '0;
                end else begin
                    if (w_xfer) begin
                        r_diff <= w_diff;
                    end
                    if (r_vld[0]) begin
                        r_sq <= w_sq;
                    end
                    if (w_clear) begin
                        r_acc <= '0;
                    end else if (r_vld[1]) begin
                        r_acc <= r_acc + {{CNT_W{1'b0}}, r_sq};
                    end
                end
            end

            assign sse[gi*ACC_W +: ACC_W] = r_acc;

`ifdef PIX_SSE_CMP_MAXDIFF_EN
            logic [DW-1:0] r_max;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_max <= '0;
                end else if (w_clear) begin
                    r_max <= '0;
                end else if (r_vld[0] && (w_abs > r_max)) begin
                    r_max <= w_abs;
                end
            end

            assign max_diff[gi*DW +: DW] = r_max;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pix_sse_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_pix_sse_cmp
// Description : Directed self-checking bench for pix_sse_cmp with a frame-level
//               reference model and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pix_sse_cmp;

    localparam int DW    = 8;
    localparam int CH    = 3;
    localparam int CNT_W = 24;
    localparam int ACC_W = 2*DW + CNT_W;

    logic                clk      = 1'b0;
    logic                resetn   = 1'b0;
    logic                start    = 1'b0;
    logic [CNT_W-1:0]    pix_num  = '0;
    logic                in_valid = 1'b0;
    logic                in_last  = 1'b0;
    logic [CH*DW-1:0]    a_pix    = '0;
    logic [CH*DW-1:0]    b_pix    = '0;
    wire                 in_ready;
    wire                 busy;
    wire                 done;
    wire                 len_err;
    wire [CH*ACC_W-1:0]  sse;
`ifdef PIX_SSE_CMP_MAXDIFF_EN
    wire [CH*DW-1:0]     max_diff;
`endif

    pix_sse_cmp #(.DW(DW), .CH(CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .pix_num  (pix_num),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .a_pix    (a_pix),
        .b_pix    (b_pix),
        .busy     (busy),
        .done     (done),
        .len_err  (len_err),
        .sse      (sse)
`ifdef PIX_SSE_CMP_MAXDIFF_EN
        ,
        .max_diff (max_diff)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference model: tracks phase, SSE, max |a-b| and done time.
    bit     m_run     = 1'b0;
    bit     m_busy    = 1'b0;
    bit     m_len_err = 1'b0;
    int     m_done_cyc = -1;
    int     m_count   = 0;
    int     m_pixnum  = 0;
    longint m_sse [CH];
    int     m_max [CH];

    always @(posedge clk) begin : p_model
        bit idle_pre;
        int d;
        cyc++;
        if (!resetn) begin
            m_run = 1'b0; m_busy = 1'b0; m_len_err = 1'b0; m_done_cyc = -1;
            for (int c = 0; c < CH; c++) begin m_sse[c] = 0; m_max[c] = 0; end
        end else begin
            idle_pre = !m_busy && !m_run && (m_done_cyc != cyc - 1);
            if (m_run && in_valid) begin
                m_count++;
                for (int c = 0; c < CH; c++) begin
                    d = int'(a_pix[c*DW +: DW]) - int'(b_pix[c*DW +: DW]);
                    m_sse[c] += longint'(d * d);
                    if (d < 0) d = -d;
                    if (d > m_max[c]) m_max[c] = d;
                end
                if (m_count == m_pixnum || in_last) begin
                    m_run      = 1'b0;
                    m_len_err  = !(m_count == m_pixnum && in_last);
                    m_done_cyc = cyc + 4;
                end
            end
            if (m_busy && m_done_cyc == cyc) m_busy = 1'b0;
            if (start && idle_pre) begin
                m_len_err = 1'b0;
                m_count   = 0;
                for (int c = 0; c < CH; c++) begin m_sse[c] = 0; m_max[c] = 0; end
                if (pix_num == '0) begin
                    m_done_cyc = cyc;
                end else begin
                    m_pixnum = int'(pix_num);
                    m_run    = 1'b1;
                    m_busy   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : p_cmp
        if (resetn) begin
            chk("in_ready", in_ready, m_run);
            chk("busy", busy, m_busy);
            chk("done", done, (cyc == m_done_cyc));
            if (done) n_done++;
            if (!m_busy && !m_run) begin
                chk("len_err", len_err, m_len_err);
                for (int c = 0; c < CH; c++) begin
                    chk($sformatf("sse[%0d]", c), sse[c*ACC_W +: ACC_W], m_sse[c]);
`ifdef PIX_SSE_CMP_MAXDIFF_EN
                    chk($sformatf("max_diff[%0d]", c), max_diff[c*DW +: DW], m_max[c]);
`endif
                end
            end
        end
    end

    function automatic logic [CH*DW-1:0] px(input int c0, input int c1, input int c2);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic start_frame(input int n);
        start   = 1'b1;
        pix_num = CNT_W'(n);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic send(input logic [CH*DW-1:0] a, input logic [CH*DW-1:0] b,
                        input bit last, output int tcyc);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; a_pix = a; b_pix = b; in_last = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        tcyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
        chk("beat_accepted", ok, 1'b1);
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin dcyc = cyc; break; end
        end
        @(posedge clk); #1;
        chk("done_seen", (dcyc >= 0), 1'b1);
    endtask

    task automatic chk_sse(input string tag, input longint e0, input longint e1, input longint e2);
        chk({tag, "_sse0"}, sse[0*ACC_W +: ACC_W], e0);
        chk({tag, "_sse1"}, sse[1*ACC_W +: ACC_W], e1);
        chk({tag, "_sse2"}, sse[2*ACC_W +: ACC_W], e2);
    endtask

    initial begin : p_stim
        int t, d, s, nd;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_sse", sse, '0);
        @(posedge clk); #1;

        // Single pixel frame
        start_frame(1);
        send(px(10, 20, 30), px(13, 20, 25), 1'b1, t);
        wait_done(d);
        chk("t1_latency", d - t, 4);
        chk_sse("t1", 9, 0, 25);
        chk("t1_len_err", len_err, 1'b0);

        // Four beats with gaps, diffs 1..4 of mixed sign
        nd = n_done;
        start_frame(4);
        for (int k = 1; k <= 4; k++) begin
            send(px(100 + k, 100, 100 + k), px(100, 100 + k, 100), (k == 4), t);
            if (k != 4) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        chk("t2_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        wait_done(d);
        chk("t2_latency", d - t, 4);
        repeat (4) @(posedge clk); #1;
        chk("t2_one_done", n_done - nd, 1);
        chk_sse("t2", 30, 30, 30);
        chk("t2_len_err", len_err, 1'b0);

        // Empty frame
        start_frame(0);
        s = cyc;
        chk("t3_in_ready", in_ready, 1'b0);
        wait_done(d);
        chk("t3_latency", d - s, 0);
        chk_sse("t3", 0, 0, 0);
        chk("t3_len_err", len_err, 1'b0);

        // Early in_last on beat 3 of 5
        start_frame(5);
        for (int k = 1; k <= 3; k++) send(px(12, 12, 12), px(10, 14, 10), (k == 3), t);
        wait_done(d);
        chk("t4_latency", d - t, 4);
        chk_sse("t4", 12, 12, 12);
        chk("t4_len_err", len_err, 1'b1);

        // in_last never asserted
        start_frame(3);
        for (int k = 1; k <= 3; k++) send(px(3, 0, 9), px(0, 3, 6), 1'b0, t);
        wait_done(d);
        chk("t5_latency", d - t, 4);
        chk_sse("t5", 27, 27, 27);
        chk("t5_len_err", len_err, 1'b1);

        // Reset mid-frame after beat 2
        nd = n_done;
        start_frame(3);
        for (int k = 1; k <= 2; k++) send(px(7, 7, 7), px(1, 1, 1), 1'b0, t);
        resetn = 1'b0;
        #1;
        chk("t6_rst_ready", in_ready, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_len_err", len_err, 1'b0);
        chk("t6_rst_sse", sse, '0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("t6_no_done", n_done - nd, 0);
        start_frame(2);
        send(px(1, 2, 3), px(4, 6, 8), 1'b0, t);
        send(px(1, 2, 3), px(4, 6, 8), 1'b1, t);
        wait_done(d);
        chk("t6_latency", d - t, 4);
        chk_sse("t6", 18, 32, 50);
        chk("t6_len_err", len_err, 1'b0);

`ifdef PIX_SSE_CMP_MAXDIFF_EN
        start_frame(3);
        send(px(255, 255, 255), px(0, 0, 0), 1'b0, t);
        send(px(5, 5, 5), px(0, 0, 0), 1'b0, t);
        send(px(0, 0, 0), px(5, 5, 5), 1'b1, t);
        wait_done(d);
        chk_sse("t7", 65075, 65075, 65075);
        for (int c = 0; c < CH; c++) chk($sformatf("t7_max%0d", c), max_diff[c*DW +: DW], 255);
        chk("t7_len_err", len_err, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
